// File: rtl/four_way_rr_arbiter_if.sv
// Channel bundle between four requesters, the round-robin arbiter and its sink.
// Debug fields expose the arbiter's internal state, beat count and last-granted index.
interface four_way_rr_arbiter_if;
    // Valid/ready: a beat moves on a rising clk edge where out_valid and out_ready
    // are both high; out_valid and out_data stay stable while out_ready is low.
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       dbg_state;
    logic [3:0] dbg_count;
    logic [1:0] dbg_last;

    modport master (
        output req, a, b, c, d, out_ready,
        input  out_valid, out_data, sel, gnt, busy, dbg_state, dbg_count, dbg_last
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output out_valid, out_data, sel, gnt, busy, dbg_state, dbg_count, dbg_last
    );
endinterface

// File: rtl/four_way_rr_arbiter.sv
// Four-way round-robin arbiter holding each grant for up to HOLD_MAX beats.
// Optional RR_ARB_LOCK_EN adds a lock input that suppresses the beat-limit release.
module four_way_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef RR_ARB_LOCK_EN
    input  logic lock,
`endif
    four_way_rr_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIM = HOLD_MAX[3:0];

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] count_q, count_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] count_inc;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       req_sel;
    logic       xfer;
    logic       hold_hit;

    assign req_sel = bus.req[sel_q];
    assign xfer    = (state_q == GRANT) && req_sel && bus.out_ready;
    // Saturate so a long locked grant cannot wrap back below the limit.
    assign count_inc = (count_q == 4'hF) ? count_q : count_q + 4'd1;

`ifdef RR_ARB_LOCK_EN
    assign hold_hit = !lock && (count_inc >= HOLD_LIM);
`else
    assign hold_hit = (count_inc >= HOLD_LIM);
`endif

    // First requester at or after last+1, wrapping modulo 4.
    always_comb begin
        pick  = last_q + 2'd1;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        count_d = count_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    count_d = 4'd0;
                end
            end
            GRANT: begin
                if (!req_sel || (xfer && hold_hit)) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                    count_d = 4'd0;
                    gnt_d   = 4'b0000;
                end else if (xfer) begin
                    count_d = count_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            count_q <= 4'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        bus.out_data = 4'b0000;
        if (state_q == GRANT) begin
            case (sel_q)
                2'd0:    bus.out_data = bus.a;
                2'd1:    bus.out_data = bus.b;
                2'd2:    bus.out_data = bus.c;
                default: bus.out_data = bus.d;
            endcase
        end
    end

    assign bus.out_valid = (state_q == GRANT) && req_sel;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.dbg_state = state_q;
    assign bus.dbg_count = count_q;
    assign bus.dbg_last  = last_q;
endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// Directed bench for four_way_rr_arbiter (HOLD_MAX = 4).
// Observed word layout: {gnt[3:0], busy, out_valid, out_data[3:0], count[3:0]}.
module tb_four_way_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    four_way_rr_arbiter_if bus ();

    four_way_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef RR_ARB_LOCK_EN
        .lock (lock),
`endif
        .bus  (bus)
    );

    wire [13:0] obs = {bus.gnt, bus.busy, bus.out_valid, bus.out_data, bus.dbg_count};

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy);
        bus.req       = r;
        bus.out_ready = rdy;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        drive(4'b0000, 1'b0);
        bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
        rst = 1'b1;
        tick(); tick();
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL reset_outs: got %b want %b", obs, exp); end
        n_cmp++;
        if ({bus.sel, bus.dbg_last} !== 4'b0011) begin
            n_bad++; $display("FAIL reset_sel_last: got %b want 0011", {bus.sel, bus.dbg_last});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL idle_no_req: got %b want %b", obs, exp); end
    endtask

    task automatic test_round_robin();
        logic [13:0] exp;
        logic [3:0]  g1h;
        logic [3:0]  dat;
        drive(4'b1111, 1'b1);
        for (int g = 0; g < 5; g++) begin
            g1h = 4'b0001 << (g % 4);
            dat = 4'((g % 4) + 1);
            for (int k = 0; k < 4; k++) begin
                tick();
                exp = {g1h, 1'b1, 1'b1, dat, 4'(k)};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++; $display("FAIL rr_g%0d_beat%0d: got %b want %b", g, k, obs, exp);
                end
            end
            tick();
            exp = 14'b0;
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL rr_gap%0d: got %b want %b", g, obs, exp); end
        end
        drive(4'b0000, 1'b1);
    endtask

    task automatic test_early_drop();
        logic [13:0] exp;
        bus.c = 4'hA;
        drive(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = {4'b0100, 1'b1, 1'b1, 4'hA, 4'(k)};
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL drop_beat%0d: got %b want %b", k, obs, exp); end
        end
        drive(4'b0000, 1'b1);
        #1;
        exp = {4'b0100, 1'b1, 1'b0, 4'hA, 4'd2};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL drop_valid_low: got %b want %b", obs, exp); end
        tick();
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL drop_idle: got %b want %b", obs, exp); end
        n_cmp++;
        if (bus.dbg_last !== 2'd2) begin n_bad++; $display("FAIL drop_last: got %0d want 2", bus.dbg_last); end
    endtask

    task automatic test_backpressure_priority();
        logic [13:0] exp;
        bus.b = 4'h5;
        bus.d = 4'h9;
        drive(4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = {4'b0010, 1'b1, 1'b1, 4'h5, 4'd0};
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL stall%0d: got %b want %b", k, obs, exp); end
            if (k == 1) drive(4'b1011, 1'b0);
        end
        drive(4'b1011, 1'b1);
        tick();
        exp = {4'b0010, 1'b1, 1'b1, 4'h5, 4'd1};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL stall_release: got %b want %b", obs, exp); end
        drive(4'b1001, 1'b1);
        tick();
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp || bus.dbg_last !== 2'd1) begin
            n_bad++; $display("FAIL prio_idle: got %b last %0d want %b last 1", obs, bus.dbg_last, exp);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = {4'b1000, 1'b1, 1'b1, 4'h9, 4'(k)};
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL prio_r3_%0d: got %b want %b", k, obs, exp); end
        end
        tick();
        tick();
        exp = {4'b0001, 1'b1, 1'b1, 4'h1, 4'd0};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL prio_r0: got %b want %b", obs, exp); end
        drive(4'b0000, 1'b1);
        tick();
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL prio_end: got %b want %b", obs, exp); end
    endtask

    task automatic test_reset_mid_grant();
        logic [13:0] exp;
        drive(4'b0010, 1'b1);
        tick();
        tick();
        exp = {4'b0010, 1'b1, 1'b1, 4'h5, 4'd1};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL mid_pre: got %b want %b", obs, exp); end
        #2;
        rst = 1'b1;
        #1;
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp || bus.sel !== 2'b00 || bus.dbg_last !== 2'b11) begin
            n_bad++; $display("FAIL mid_async: got %b sel %0d last %0d want %b sel 0 last 3",
                              obs, bus.sel, bus.dbg_last, exp);
        end
        tick();
        rst = 1'b0;
        tick();
        exp = {4'b0010, 1'b1, 1'b1, 4'h5, 4'd0};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL mid_resume: got %b want %b", obs, exp); end
        drive(4'b0000, 1'b1);
        tick();
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        logic [13:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lock = 1'b1;
        drive(4'b0011, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp = {4'b0001, 1'b1, 1'b1, 4'h1, 4'(k)};
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL lock_%0d: got %b want %b", k, obs, exp); end
        end
        lock = 1'b0;
        tick();
        exp = 14'b0;
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL lock_release: got %b want %b", obs, exp); end
        drive(4'b0000, 1'b1);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_early_drop();
        test_backpressure_priority();
        test_reset_mid_grant();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
